// File: rtl/reg_bank_pkg.sv
// Shared definitions for the write side of the datapath register file:
// data/register-count constants, the register-select type and the
// hold-buffer state encoding.
package reg_bank_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 16;

  typedef logic [3:0]       sel_t;
  typedef logic [WIDTH-1:0] data_t;

  // EMPTY: load port free, ld_ready high.
  // HELD:  a collided load is parked in the hold buffer, ld_ready low.
  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank_wr_decoder.sv
// 4-to-16 write-select decoder. Produces a one-hot register enable when
// en_i is high and all zeros otherwise, so a source can never touch more
// than one register per cycle.
module reg_bank_wr_decoder
  import reg_bank_pkg::*;
(
  input  logic             en_i,
  input  sel_t             sel_i,
  output logic [NREGS-1:0] onehot_o
);

  // Single bit set at the selected position, only while enabled
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Sixteen-entry register bank write side. Two write-back sources (ALU and
// memory load) share the bank; the ALU is always the younger instruction and
// always wins. A load that collides with an ALU write to a different register
// is parked in a one-entry hold buffer and retired on the first cycle the ALU
// is idle, or dropped if the ALU overwrites its destination first.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = reg_bank_pkg::WIDTH,
  parameter int NREGS = reg_bank_pkg::NREGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_wr_en,
  input  logic [3:0]       alu_wr_sel,
  input  logic [WIDTH-1:0] alu_wr_data,
  input  logic             ld_wr_en,
  input  logic [3:0]       ld_wr_sel,
  input  logic [WIDTH-1:0] ld_wr_data,
  output logic             ld_ready,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15
);

  // Hold-buffer state machine
  state_t           state_q, state_d;
  sel_t             holdSel_q, holdSel_d;
  logic [WIDTH-1:0] holdData_q, holdData_d;
  logic             ldReady_q;

  // The register file itself
  logic [WIDTH-1:0] regs_q [NREGS];

  // Load-side write candidate: either the live load port or the hold buffer
  logic             pendValid;
  sel_t             pendSel;
  logic [WIDTH-1:0] pendData;
  logic             ldWrite;

  // Per-source decoded enables and merged per-register write controls
  logic [NREGS-1:0] aluHot;
  logic [NREGS-1:0] ldHot;
  logic [NREGS-1:0] wrEn;
  logic [WIDTH-1:0] wrData [NREGS];

  // Pick the load-side candidate and decide whether it is written, parked or
  // dropped; the ALU write itself is never delayed
  always_comb begin
    pendValid  = 1'b0;
    pendSel    = ld_wr_sel;
    pendData   = ld_wr_data;
    ldWrite    = 1'b0;
    state_d    = state_q;
    holdSel_d  = holdSel_q;
    holdData_d = holdData_q;

    case (state_q)
      EMPTY: begin
        pendValid = ld_wr_en;
        pendSel   = ld_wr_sel;
        pendData  = ld_wr_data;
      end
      HELD: begin
        pendValid = 1'b1;
        pendSel   = holdSel_q;
        pendData  = holdData_q;
      end
      default: begin
        pendValid = 1'b0;
      end
    endcase

    if (pendValid) begin
      if (!alu_wr_en) begin
        ldWrite = 1'b1;
        state_d = EMPTY;
      end else if (alu_wr_sel != pendSel) begin
        state_d    = HELD;
        holdSel_d  = pendSel;
        holdData_d = pendData;
      end else begin
        state_d = EMPTY;
      end
    end else begin
      state_d = EMPTY;
    end
  end

  reg_bank_wr_decoder u_aluDec (
    .en_i     (alu_wr_en),
    .sel_i    (alu_wr_sel),
    .onehot_o (aluHot)
  );

  reg_bank_wr_decoder u_ldDec (
    .en_i     (ldWrite),
    .sel_i    (pendSel),
    .onehot_o (ldHot)
  );

  // Merge both sources into one enable per register, ALU data taking priority
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      wrEn[i]   = aluHot[i] | ldHot[i];
      wrData[i] = aluHot[i] ? alu_wr_data : pendData;
    end
  end

  // Hold buffer, state and registered ld_ready; reset frees the load port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      holdSel_q  <= '0;
      holdData_q <= '0;
      ldReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      holdSel_q  <= holdSel_d;
      holdData_q <= holdData_d;
      ldReady_q  <= (state_d == EMPTY);
    end
  end

  // Register file update, at most one register per source per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wrEn[i]) begin
          regs_q[i] <= wrData[i];
        end
      end
    end
  end

  assign ld_ready = ldReady_q;

  assign r0  = regs_q[0];
  assign r1  = regs_q[1];
  assign r2  = regs_q[2];
  assign r3  = regs_q[3];
  assign r4  = regs_q[4];
  assign r5  = regs_q[5];
  assign r6  = regs_q[6];
  assign r7  = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];
  assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank. A behavioural model of the register file
// and hold buffer predicts every register and ld_ready after each edge; the
// predictions go into a scoreboard queue and are compared once the DUT has
// updated.
module tb_reg_bank;

  typedef struct {
    string       tag;
    int          idx;
    logic [15:0] val;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        aluWrEn;
  logic [3:0]  aluWrSel;
  logic [15:0] aluWrData;
  logic        ldWrEn;
  logic [3:0]  ldWrSel;
  logic [15:0] ldWrData;
  logic        ldReady;
  logic [15:0] rOut [16];

  logic [15:0] modelRegs [16];
  logic        modelHeld;
  logic [3:0]  modelHoldSel;
  logic [15:0] modelHoldData;

  exp_t  sbQueue [$];
  int    testsRun;
  int    testsFailed;
  string stepName;

  reg_bank dut (
    .clk         (clock),
    .reset       (reset),
    .alu_wr_en   (aluWrEn),
    .alu_wr_sel  (aluWrSel),
    .alu_wr_data (aluWrData),
    .ld_wr_en    (ldWrEn),
    .ld_wr_sel   (ldWrSel),
    .ld_wr_data  (ldWrData),
    .ld_ready    (ldReady),
    .r0          (rOut[0]),
    .r1          (rOut[1]),
    .r2          (rOut[2]),
    .r3          (rOut[3]),
    .r4          (rOut[4]),
    .r5          (rOut[5]),
    .r6          (rOut[6]),
    .r7          (rOut[7]),
    .r8          (rOut[8]),
    .r9          (rOut[9]),
    .r10         (rOut[10]),
    .r11         (rOut[11]),
    .r12         (rOut[12]),
    .r13         (rOut[13]),
    .r14         (rOut[14]),
    .r15         (rOut[15])
  );

  // Free-running 10-time-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s (%s): observed %h expected %h", tag, stepName,
               observed, expected);
    end
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic modelStep(input logic aluEn, input logic [3:0] aluSel,
                           input logic [15:0] aluData, input logic ldEn,
                           input logic [3:0] ldSel, input logic [15:0] ldData);
    if (!modelHeld) begin
      if (aluEn && ldEn) begin
        modelRegs[aluSel] = aluData;
        if (ldSel != aluSel) begin
          modelHeld     = 1'b1;
          modelHoldSel  = ldSel;
          modelHoldData = ldData;
        end
      end else if (aluEn) begin
        modelRegs[aluSel] = aluData;
      end else if (ldEn) begin
        modelRegs[ldSel] = ldData;
      end
    end else begin
      if (!aluEn) begin
        modelRegs[modelHoldSel] = modelHoldData;
        modelHeld = 1'b0;
      end else if (aluSel == modelHoldSel) begin
        modelRegs[aluSel] = aluData;
        modelHeld = 1'b0;
      end else begin
        modelRegs[aluSel] = aluData;
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelRegs[i] = 16'h0000;
    modelHeld     = 1'b0;
    modelHoldSel  = 4'h0;
    modelHoldData = 16'h0000;
  endtask

  // Queue the model's view of every register plus ld_ready
  task automatic pushExpected();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.tag = $sformatf("r%0d", i);
      e.idx = i;
      e.val = modelRegs[i];
      sbQueue.push_back(e);
    end
    e.tag = "ld_ready";
    e.idx = 16;
    e.val = {15'b0, ~modelHeld};
    sbQueue.push_back(e);
  endtask

  // Pop every queued expectation and compare against the DUT outputs
  task automatic drainScoreboard();
    exp_t        e;
    logic [15:0] obs;
    while (sbQueue.size() > 0) begin
      e   = sbQueue.pop_front();
      obs = (e.idx == 16) ? {15'b0, ldReady} : rOut[e.idx];
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  // Drive one cycle of stimulus mid-cycle, predict, then check after the edge
  task automatic applyStimulus(input logic aluEn, input logic [3:0] aluSel,
                               input logic [15:0] aluData, input logic ldEn,
                               input logic [3:0] ldSel, input logic [15:0] ldData);
    aluWrEn   = aluEn;
    aluWrSel  = aluSel;
    aluWrData = aluData;
    ldWrEn    = ldEn;
    ldWrSel   = ldSel;
    ldWrData  = ldData;
    if (ldEn) checkOutput("ldReadyAtLoadRequest", {15'b0, ldReady}, 16'h0001);
    modelStep(aluEn, aluSel, aluData, ldEn, ldSel, ldData);
    pushExpected();
    @(posedge clock);
    #1;
    drainScoreboard();
    aluWrEn = 1'b0;
    ldWrEn  = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
  endtask

  // Assert reset mid-cycle, check it acts without a clock edge, hold it across
  // one edge, then release it mid-cycle
  task automatic applyReset();
    aluWrEn = 1'b0;
    ldWrEn  = 1'b0;
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    pushExpected();
    drainScoreboard();
    @(posedge clock);
    #1;
    pushExpected();
    drainScoreboard();
    #1;
    reset = 1'b0;
    #1;
  endtask

  // Directed scenarios followed by a constrained-random soak
  initial begin
    logic        rAluEn;
    logic        rLdEn;
    logic [3:0]  rAluSel;
    logic [3:0]  rLdSel;
    logic [15:0] rAluData;
    logic [15:0] rLdData;

    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    aluWrEn     = 1'b0;
    aluWrSel    = 4'h0;
    aluWrData   = 16'h0000;
    ldWrEn      = 1'b0;
    ldWrSel     = 4'h0;
    ldWrData    = 16'h0000;
    modelReset();

    stepName = "powerOnReset";
    #12;
    pushExpected();
    drainScoreboard();
    reset = 1'b0;
    #5;

    stepName = "aluWriteR3";
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000);
    stepName = "loadWriteR15";
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 16'h00FF);
    stepName = "aluWriteR5";
    applyStimulus(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000);
    stepName = "resetMidRun";
    applyReset();

    stepName = "collideDiffSel";
    applyStimulus(1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd7, 16'h5555);
    stepName = "collideDiffSelDrain";
    idleCycle();
    stepName = "collideDiffSelAfter";
    idleCycle();

    stepName = "collideSameSel";
    applyStimulus(1'b1, 4'd4, 16'h1111, 1'b1, 4'd4, 16'h2222);
    idleCycle();

    stepName = "heldRetain";
    applyStimulus(1'b1, 4'd0, 16'h0A0A, 1'b1, 4'd9, 16'h0F0F);
    applyStimulus(1'b1, 4'd1, 16'h0101, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b1, 4'd2, 16'h0202, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b1, 4'd3, 16'h0303, 1'b0, 4'd0, 16'h0000);
    stepName = "heldRetainDrain";
    idleCycle();

    stepName = "heldDiscard";
    applyStimulus(1'b1, 4'd9, 16'h0000, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b1, 4'd8, 16'h0808, 1'b1, 4'd9, 16'h0F0F);
    applyStimulus(1'b1, 4'd9, 16'h7777, 1'b0, 4'd0, 16'h0000);
    stepName = "heldDiscardAfter";
    idleCycle();
    idleCycle();

    stepName = "resetDuringHeld";
    applyStimulus(1'b1, 4'd10, 16'h1010, 1'b1, 4'd6, 16'hCAFE);
    applyReset();
    stepName = "afterResetRelease";
    idleCycle();
    idleCycle();

    stepName = "randomSoak";
    for (int n = 0; n < 400; n++) begin
      rAluEn   = 1'($urandom_range(0, 1));
      rLdEn    = modelHeld ? 1'b0 : 1'($urandom_range(0, 1));
      rAluSel  = 4'($urandom_range(0, 15));
      rLdSel   = (n % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rAluData = 16'($urandom);
      rLdData  = 16'($urandom);
      applyStimulus(rAluEn, rAluSel, rAluData, rLdEn, rLdSel, rLdData);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
